vga_code_loader: RTL and testbench
==================================

VGA_CODE_LOADER -- requirements
Module: vga_code_loader

Interface
REQ-001 SHALL have parameter RESET_CODE, default 24'hF000F0, code value after reset (left red, right green).
REQ-002 SHALL have parameter TIMEOUT, default 1023, maximum idle cycles between bytes of one message; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  input  8  message byte.
REQ-006 SHALL have port in_valid  input  1  in_data/in_last valid.
REQ-007 SHALL have port in_last  input  1  marks final byte of a message.
REQ-008 SHALL have port in_ready  output  1  byte accepted when in_valid&&in_ready at a clk edge.
REQ-009 SHALL have port vsync  input  1  active-low VSYNC from the downstream VGA timing stage.
REQ-010 SHALL have port code  output  24  {left RGB444, right RGB444}, feeds the VGA stage's code input.
REQ-011 SHALL have port update_done  output  1  one-cycle pulse when code changes.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on a discarded message.

Function
REQ-013 Message SHALL be exactly 3 bytes, big-endian: byte0->code[23:16], byte1->code[15:8], byte2->code[7:0].
REQ-014 FSM states SHALL be B0 (expect byte0), B1, B2, PEND (message complete, awaiting commit).
REQ-015 in_ready SHALL be 1 in B0/B1/B2, 0 in PEND and during rst; it is a registered output.
REQ-016 Accepted bytes SHALL go to a 24-bit shadow register; code SHALL never show a partially assembled value.
REQ-017 in_last=1 on byte0 or byte1, or in_last=0 on byte2, SHALL discard the message, pulse frame_err, and return to B0.
REQ-018 Valid byte2 with in_last=1 SHALL move to PEND (frame-sync build) or commit directly (see Configuration).
REQ-019 Timeout counter SHALL clear on each accepted byte and count cycles in B1/B2 with no accept; reaching TIMEOUT (TIMEOUT>0) SHALL pulse frame_err and return to B0.
REQ-020 Timeout counter SHALL be 16 bits, held at 0 in B0 and PEND.
REQ-021 vsync SHALL be registered once (vsync_q); the commit event is vsync_q==1 && vsync==0 (start of sync pulse).
REQ-022 Commit SHALL load code from shadow and pulse update_done in the cycle after the commit edge, then return to B0.
REQ-023 If the commit event and PEND entry fall on the same edge, commit SHALL wait for the next vsync falling edge.
REQ-024 frame_err and update_done SHALL never pulse in the same cycle.

Reset
REQ-025 rst SHALL set code=RESET_CODE, state=B0, shadow=0, in_ready=0, update_done=0, frame_err=0, vsync_q=1, timeout counter=0.
REQ-026 rst mid-message or in PEND SHALL discard pending data; no update_done is issued.
REQ-027 in_ready SHALL rise one cycle after rst deasserts.

Configuration
REQ-028 Macro VGA_CODE_LOADER_FRAME_SYNC_EN defined: PEND state exists; commit only at vsync falling edge (tear-free).
REQ-029 Macro undefined: PEND and vsync_q omitted, vsync ignored; code loads and update_done pulses the cycle after byte2 acceptance; in_ready stays 1.

Structure
REQ-030 Shared package vga_pkg SHALL hold the FSM state encoding, message length 3, and RGB444 field widths/offsets.
REQ-031 Timeout counter SHALL be a sub-module vga_timeout_cnt (enable, clear, expired).
REQ-032 Target size 120-400 lines of RTL; no other sub-modules.

Verification
REQ-033 Reset: rst high 3 cycles -> code=24'hF000F0, in_ready=0; one cycle after release in_ready=1.
REQ-034 Bytes 8'h12, 8'h34, 8'h56 (last on third), FRAME_SYNC_EN -> code unchanged until vsync 1->0, then code=24'h123456 with a single update_done pulse; in_ready=0 while pending.
REQ-035 Same bytes without macro -> code=24'h123456 the cycle after byte2 acceptance.
REQ-036 Bytes 8'hAA with in_last=1 -> frame_err pulse, code unchanged, next 3-byte message 8'h00, 8'h0F, 8'hF0 -> code=24'h000FF0.
REQ-037 TIMEOUT=8: byte0 accepted then 8 idle cycles -> frame_err pulse, state B0; next byte treated as byte0.
REQ-038 rst asserted in PEND, then vsync falling edge -> code=RESET_CODE, no update_done.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA code loader: FSM state encoding, message
// length and RGB444 field layout of the 24-bit code word.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_B0,
    ST_B1,
    ST_B2,
    ST_PEND
  } state_e;

  localparam int unsigned MSG_LEN   = 3;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned RGB_CH_W  = 4;
  localparam int unsigned RGB_W     = 3 * RGB_CH_W;
  localparam int unsigned CODE_W    = 2 * RGB_W;
  localparam int unsigned LEFT_OFF  = RGB_W;
  localparam int unsigned RIGHT_OFF = 0;

  // Messages are big-endian: byte 0 lands in the most significant byte.
  function automatic int unsigned byte_lsb(input int unsigned idx);
    return (MSG_LEN - 1 - idx) * BYTE_W;
  endfunction

endpackage

// File: rtl/vga_timeout_cnt.sv
// Inter-byte idle counter: counts enabled cycles, flags the cycle whose
// count would reach TIMEOUT. TIMEOUT of 0 never expires.
module vga_timeout_cnt #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned    CNT_W = 16;
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Expires on the edge at which the idle count reaches TIMEOUT.
  assign expired_o = (TIMEOUT != 0) && enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/vga_code_loader.sv
// Assembles 3-byte messages into the 24-bit VGA colour code. With
// VGA_CODE_LOADER_FRAME_SYNC_EN defined, the commit waits for a vsync falling edge.
module vga_code_loader
  import vga_pkg::*;
#(
  parameter logic [23:0] RESET_CODE = 24'hF000F0,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              vsync,
  output logic [CODE_W-1:0] code,
  output logic              update_done,
  output logic              frame_err
);

  state_e            state_q;
  logic [CODE_W-1:0] shadow_q;
  logic [CODE_W-1:0] code_q;
  logic              in_ready_q;
  logic              update_done_q;
  logic              frame_err_q;
  logic              accept;
  logic              tmo_en;
  logic              tmo_expired;

  assign accept = in_valid && in_ready_q;
  assign tmo_en = ((state_q == ST_B1) || (state_q == ST_B2)) && !accept;

  vga_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .enable_i  (tmo_en),
    .clear_i   (!tmo_en),
    .expired_o (tmo_expired)
  );

`ifdef VGA_CODE_LOADER_FRAME_SYNC_EN
  logic vsync_q;
  logic vsync_fall;
  assign vsync_fall = vsync_q && !vsync;
`else
  logic unused_sync;
  assign unused_sync = ^{vsync, shadow_q[byte_lsb(2) +: BYTE_W]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_B0;
      shadow_q      <= '0;
      code_q        <= RESET_CODE;
      in_ready_q    <= 1'b0;
      update_done_q <= 1'b0;
      frame_err_q   <= 1'b0;
`ifdef VGA_CODE_LOADER_FRAME_SYNC_EN
      vsync_q       <= 1'b1;
`endif
    end else begin
      update_done_q <= 1'b0;
      frame_err_q   <= 1'b0;
      in_ready_q    <= 1'b1;
`ifdef VGA_CODE_LOADER_FRAME_SYNC_EN
      vsync_q       <= vsync;
`endif
      unique case (state_q)
        ST_B0: begin
          if (accept) begin
            shadow_q[byte_lsb(0) +: BYTE_W] <= in_data;
            if (in_last) frame_err_q <= 1'b1;
            else         state_q     <= ST_B1;
          end
        end
        ST_B1: begin
          if (accept) begin
            shadow_q[byte_lsb(1) +: BYTE_W] <= in_data;
            if (in_last) begin
              frame_err_q <= 1'b1;
              state_q     <= ST_B0;
            end else begin
              state_q     <= ST_B2;
            end
          end else if (tmo_expired) begin
            frame_err_q <= 1'b1;
            state_q     <= ST_B0;
          end
        end
        ST_B2: begin
          if (accept) begin
            if (!in_last) begin
              frame_err_q <= 1'b1;
              state_q     <= ST_B0;
            end else begin
`ifdef VGA_CODE_LOADER_FRAME_SYNC_EN
              shadow_q[byte_lsb(2) +: BYTE_W] <= in_data;
              in_ready_q <= 1'b0;
              state_q    <= ST_PEND;
`else
              // Last byte bypasses the shadow so code updates the next cycle.
              code_q        <= {shadow_q[CODE_W-1:BYTE_W], in_data};
              update_done_q <= 1'b1;
              state_q       <= ST_B0;
`endif
            end
          end else if (tmo_expired) begin
            frame_err_q <= 1'b1;
            state_q     <= ST_B0;
          end
        end
        ST_PEND: begin
`ifdef VGA_CODE_LOADER_FRAME_SYNC_EN
          if (vsync_fall) begin
            code_q        <= shadow_q;
            update_done_q <= 1'b1;
            state_q       <= ST_B0;
          end else begin
            in_ready_q <= 1'b0;
          end
`else
          state_q <= ST_B0;
`endif
        end
        default: state_q <= ST_B0;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign code        = code_q;
  assign update_done = update_done_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_vga_code_loader.sv
// Directed bench for vga_code_loader; expected codes go through a scoreboard
// checked whenever update_done pulses. Works with or without VGA_CODE_LOADER_FRAME_SYNC_EN.
module tb_vga_code_loader;

  localparam logic [23:0] RST_CODE = 24'hF000F0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        vsync = 1'b1;
  logic        in_ready;
  logic [23:0] code;
  logic        update_done;
  logic        frame_err;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int err_seen = 0;
  int done_exp = 0;
  int err_exp = 0;
  logic [23:0] sb[$];

  always #5 clk = ~clk;

  vga_code_loader #(
    .RESET_CODE(RST_CODE),
    .TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .vsync       (vsync),
    .code        (code),
    .update_done (update_done),
    .frame_err   (frame_err)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Scoreboard side: every update_done pulse must match the oldest queued code.
  always @(posedge clk) begin
    #1;
    if (frame_err === 1'b1) err_seen++;
    if (update_done === 1'b1) begin
      done_seen++;
      chk_bit("no_err_with_done", frame_err, 1'b0);
      if (sb.size() == 0) chk_val("sb_nonempty", 32'(sb.size()), 32'd1);
      else                chk_val("sb_code", {8'h00, code}, {8'h00, sb.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    if (n >= 40) chk_bit("ready_wait", in_ready, 1'b1);
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    sb.push_back({b0, b1, b2});
    done_exp++;
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b1);
  endtask

  // Called right after the last byte is accepted.
  task automatic commit(input logic [23:0] exp, input logic [23:0] prev);
`ifdef VGA_CODE_LOADER_FRAME_SYNC_EN
    chk_bit("ready_low_pend", in_ready, 1'b0);
    chk_val("code_held_pend", {8'h00, code}, {8'h00, prev});
    step(3);
    chk_val("code_held_wait", {8'h00, code}, {8'h00, prev});
    chk_bit("no_done_wait", update_done, 1'b0);
    vsync = 1'b0;
    step(1);
    chk_val("commit_code", {8'h00, code}, {8'h00, exp});
    chk_bit("commit_pulse", update_done, 1'b1);
    step(1);
    vsync = 1'b1;
`else
    chk_val("direct_prev_ignored", {8'h00, code}, {8'h00, (prev == exp) ? prev : exp});
    chk_bit("direct_pulse", update_done, 1'b1);
    step(1);
`endif
    chk_bit("pulse_single", update_done, 1'b0);
    chk_bit("ready_after_commit", in_ready, 1'b1);
  endtask

  initial begin
    // Reset behaviour
    rst = 1'b1;
    step(3);
    chk_val("rst_code", {8'h00, code}, {8'h00, RST_CODE});
    chk_bit("rst_ready", in_ready, 1'b0);
    chk_bit("rst_done", update_done, 1'b0);
    chk_bit("rst_err", frame_err, 1'b0);
    rst = 1'b0;
    step(1);
    chk_bit("ready_after_rst", in_ready, 1'b1);

    // Basic message
    send_msg(8'h12, 8'h34, 8'h56);
    commit(24'h123456, RST_CODE);

    // Single byte with last set
    send_byte(8'hAA, 1'b1);
    err_exp++;
    chk_bit("err_byte0_last", frame_err, 1'b1);
    chk_val("err_code_kept", {8'h00, code}, 32'h00123456);
    step(1);
    chk_bit("err_pulse_single", frame_err, 1'b0);
    send_msg(8'h00, 8'h0F, 8'hF0);
    commit(24'h000FF0, 24'h123456);

    // last on byte1, then missing last on byte2
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    err_exp++;
    chk_bit("err_byte1_last", frame_err, 1'b1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    err_exp++;
    chk_bit("err_byte2_nolast", frame_err, 1'b1);
    chk_val("err2_code_kept", {8'h00, code}, 32'h00000FF0);
    send_msg(8'h5A, 8'hA5, 8'h3C);
    commit(24'h5AA53C, 24'h000FF0);

    // Timeout after byte0: 8 idle cycles abort the message
    send_byte(8'h77, 1'b0);
    step(7);
    chk_bit("no_tmo_at_7", frame_err, 1'b0);
    step(1);
    err_exp++;
    chk_bit("tmo_at_8", frame_err, 1'b1);
    send_msg(8'hAB, 8'hCD, 8'hEF);
    commit(24'hABCDEF, 24'h5AA53C);

    // Gaps of 7 idle cycles stay within the limit
    sb.push_back(24'h010203);
    done_exp++;
    send_byte(8'h01, 1'b0);
    step(7);
    send_byte(8'h02, 1'b0);
    step(7);
    send_byte(8'h03, 1'b1);
    commit(24'h010203, 24'hABCDEF);

`ifdef VGA_CODE_LOADER_FRAME_SYNC_EN
    // Reset while pending discards the message
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b1);
    chk_bit("pend_before_rst", in_ready, 1'b0);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    vsync = 1'b0;
    step(2);
    vsync = 1'b1;
    step(1);
    chk_val("pend_rst_code", {8'h00, code}, {8'h00, RST_CODE});
`endif

    // Reset mid-message discards partial bytes
    send_byte(8'h99, 1'b0);
    send_byte(8'h88, 1'b0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_val("mid_rst_code", {8'h00, code}, {8'h00, RST_CODE});
    chk_bit("mid_rst_ready", in_ready, 1'b0);
    step(1);
    chk_bit("mid_rst_ready_up", in_ready, 1'b1);
    send_msg(8'hC0, 8'hFF, 8'hEE);
    commit(24'hC0FFEE, RST_CODE);

    step(3);
    chk_val("sb_drained", 32'(sb.size()), 32'd0);
    chk_val("done_count", 32'(done_seen), 32'(done_exp));
    chk_val("err_count", 32'(err_seen), 32'(err_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
